// File: rtl/spi_ram_arbiter_if.sv
// Bundle of requester A/B handshakes and the SPI RAM controller side of the arbiter.
// slave is the arbiter's view; master is everything around it (requesters and controller).
interface spi_ram_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 a_req;
    logic                 a_we;
    logic [ADDR_BITS-1:0] a_addr;
    logic [DATA_BITS-1:0] a_wdata;
    logic                 a_ack;
    logic [DATA_BITS-1:0] a_rdata;

    logic                 b_req;
    logic                 b_we;
    logic [ADDR_BITS-1:0] b_addr;
    logic [DATA_BITS-1:0] b_wdata;
    logic                 b_ack;
    logic [DATA_BITS-1:0] b_rdata;

    logic                 err;
    logic                 busy;

    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0] ram_data_in;
    logic                 ram_start_read;
    logic                 ram_start_write;
    logic [DATA_BITS-1:0] ram_data_out;
    logic                 ram_busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output err, busy,
        output ram_addr, ram_data_in, ram_start_read, ram_start_write,
        input  ram_data_out, ram_busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  err, busy,
        input  ram_addr, ram_data_in, ram_start_read, ram_start_write,
        output ram_data_out, ram_busy
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one SPI RAM controller between a CPU port (A) and a debug/loader port (B).
// One transaction at a time, with a WAIT timeout that completes the transaction with err set.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// ISSUE  | one-cycle read or write start pulse to the controller
// SETTLE | one cycle for the controller to raise ram_busy; ram_busy ignored
// WAIT   | wait for ram_busy low or timeout
// DONE   | one-cycle ack to the owner, err on timeout
module spi_ram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int TIMEOUT   = 255
) (
    input logic              clk,
    input logic              rst,
    spi_ram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    state_t               state, state_nxt;
    logic                 owner_q;        // 0 = A, 1 = B
    logic                 last_grant_q;   // 0 = A, 1 = B
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [7:0]           cnt_q;
    logic                 timeout_q;
    logic [DATA_BITS-1:0] a_rdata_q;
    logic [DATA_BITS-1:0] b_rdata_q;

    logic any_req;
    logic win_b;
    logic time_up;

    assign any_req = bus.a_req | bus.b_req;
    // On a tie the port that did not win last time gets the grant.
    assign win_b   = bus.b_req & (~bus.a_req | ~last_grant_q);
    assign time_up = (({1'b0, cnt_q} + 9'd1) == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_WAIT;
            S_WAIT:   if (!bus.ram_busy || time_up) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (any_req) begin
                        owner_q      <= win_b;
                        last_grant_q <= win_b;
                        we_q         <= win_b ? bus.b_we    : bus.a_we;
                        addr_q       <= win_b ? bus.b_addr  : bus.a_addr;
                        wdata_q      <= win_b ? bus.b_wdata : bus.a_wdata;
                    end
                end
                S_SETTLE: cnt_q <= '0;
                S_WAIT: begin
                    if (!bus.ram_busy) begin
                        if (!we_q) begin
                            if (owner_q) b_rdata_q <= bus.ram_data_out;
                            else         a_rdata_q <= bus.ram_data_out;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (time_up) timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy            = (state != S_IDLE);
        bus.ram_start_read  = (state == S_ISSUE) & ~we_q;
        bus.ram_start_write = (state == S_ISSUE) & we_q;
        bus.ram_addr        = '0;
        bus.ram_data_in     = '0;
        if (state == S_ISSUE || state == S_SETTLE || state == S_WAIT) begin
            bus.ram_addr = addr_q;
            if (we_q) bus.ram_data_in = wdata_q;
        end
        bus.a_ack   = (state == S_DONE) & ~owner_q;
        bus.b_ack   = (state == S_DONE) & owner_q;
        bus.err     = (state == S_DONE) & timeout_q;
        bus.a_rdata = a_rdata_q;
        bus.b_rdata = b_rdata_q;
    end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter: ADDR_BITS, 16, RAM address width.
REQ-002 Parameter: DATA_BITS, 16, RAM word width.
REQ-003 Parameter: TIMEOUT, 255, max cycles in WAIT before abort (1..255).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports, in order:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-high reset
 a_req  in  1  requester A (CPU) request, held until a_ack
 a_we  in  1  A: 1 = write, 0 = read
 a_addr  in  ADDR_BITS  A address
 a_wdata  in  DATA_BITS  A write data
 a_ack  out  1  A completion pulse
 a_rdata  out  DATA_BITS  A read data
 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  --  requester B (debug/loader), same as A
 err  out  1  timeout flag, valid with ack
 busy  out  1  transaction in progress
 ram_addr  out  ADDR_BITS  to SPI RAM controller addr_in
 ram_data_in  out  DATA_BITS  to controller data_in
 ram_start_read  out  1  read start pulse
 ram_start_write  out  1  write start pulse
 ram_data_out  in  DATA_BITS  controller read data
 ram_busy  in  1  controller busy

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, SETTLE, WAIT, DONE.
REQ-007 IDLE: if any req sampled high, latch owner, we, addr, wdata of winner; go ISSUE; else stay.
REQ-008 Arbitration SHALL be round-robin: single requester always wins; on tie, winner = requester not equal to last_grant; last_grant updates on each grant.
REQ-009 ISSUE: exactly one cycle; ram_start_write=1 if latched we, else ram_start_read=1; go SETTLE.
REQ-010 SETTLE: one cycle, ram_busy ignored; go WAIT.
REQ-011 WAIT: on ram_busy=0 go DONE; for reads capture ram_data_out into owner's rdata on that edge.
REQ-012 WAIT timeout: 8-bit counter cleared entering WAIT, increments each WAIT cycle; when it reaches TIMEOUT with ram_busy=1, go DONE with err=1, rdata unchanged.
REQ-013 DONE: one cycle; owner's ack=1 (registered), other ack=0; err=1 only on timeout; go IDLE.
REQ-014 Requester SHALL deassert req on the edge where it samples ack=1; arbiter does not sample req in DONE.
REQ-015 ram_addr/ram_data_in SHALL equal latched addr/wdata in ISSUE, SETTLE, WAIT; 0 in IDLE and DONE; ram_data_in=0 for reads.
REQ-016 Start pulses SHALL be 0 in all states but ISSUE; never both high.
REQ-017 rdata of each port SHALL hold until overwritten by that port's next completed read; writes leave it unchanged.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Minimum latency: req high at IDLE edge -> ack high 4 cycles later (ram_busy low on entering WAIT).
REQ-020 Changes to a_*/b_* inputs after grant SHALL not affect the in-flight transaction.

Reset
REQ-021 rst SHALL immediately force IDLE; all outputs 0; rdata 0; last_grant=B (A wins first tie); timeout counter 0.
REQ-022 rst mid-transaction SHALL abandon it with no ack; controller shares the same reset.

Verification
REQ-023 A read 0x0010, ram_data_out=0xBEEF, ram_busy low after SETTLE -> ram_start_read one cycle, ram_addr=0x0010, a_ack 4 cycles after req, a_rdata=0xBEEF.
REQ-024 B write 0x1234 to 0x00FF -> ram_start_write one cycle, ram_data_in=0x1234, b_ack pulse, b_rdata unchanged, a_ack stays 0.
REQ-025 A and B req together from reset -> A served first, B immediately after; next tie serves A again only after B.
REQ-026 ram_busy stuck high, TIMEOUT=255 -> DONE after 255 WAIT cycles, ack and err both 1 for one cycle, then IDLE.
REQ-027 rst asserted during WAIT -> outputs 0 same cycle, no ack; next request served normally with 4-cycle latency.
